// File: rtl/axi4_lite_wf_loader.sv
// AXI4-Lite slave that loads waveform tables into NUM_CH dual-port BRAMs.
// Provides channel select, an auto-incrementing write pointer, one-cycle
// BRAM write strobes, saturating per-channel load counters, a sticky wrap
// flag, and read-back of each channel's read-data count.
module axi4_lite_wf_loader #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int NUM_CH             = 4,
  parameter int WF_ADDR_W          = 10,
  parameter int WF_DATA_W          = 16
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  // write address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  // write data channel
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  // write response channel
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  // read address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  // read data channel
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  // waveform BRAM write port
  output logic [NUM_CH-1:0]                 o_wf_write_en,
  output logic [WF_ADDR_W-1:0]              o_wf_write_addr,
  output logic [WF_DATA_W-1:0]              o_wf_write_data,
  // per-channel read counts from the playback side
  input  logic [NUM_CH*32-1:0]              i_wf_read_data_num
);

  localparam int ADDR_LSB = 2;
  localparam int WORD_W   = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
  localparam int NB       = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [WF_ADDR_W:0] CNT_MAX = {1'b1, {WF_ADDR_W{1'b0}}};

  // AXI handshake state
  logic              awready_q, wready_q, bvalid_q, aw_en_q;
  logic [WORD_W-1:0] awaddr_q;
  logic              arready_q, rvalid_q;
  logic [WORD_W-1:0] araddr_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

  // register file
  logic [31:0]          ctrl_q, ctrl_d;
  logic [WF_ADDR_W-1:0] ptr_q, ptr_d;
  logic                 wrap_q, wrap_d;
  logic [WF_ADDR_W:0]   cnt_q [NUM_CH];
  logic [WF_ADDR_W:0]   cnt_d [NUM_CH];
  logic [NUM_CH-1:0]    wen_q, wen_d;
  logic [WF_ADDR_W-1:0] waddr_q, waddr_d;
  logic [WF_DATA_W-1:0] wdata_q, wdata_d;
  logic [31:0]          shadow_q [NUM_CH];

  logic [3:0]  chsel;
  logic        auto_inc;
  logic        chsel_invalid;
  logic        wr_fire;
  logic [31:0] wr_word;
  logic [31:0] rd_word;
  logic [31:0] rdata_mux;
  logic        unused_ok;

  assign chsel         = ctrl_q[11:8];
  assign auto_inc      = ctrl_q[0];
  assign chsel_invalid = (int'(chsel) >= NUM_CH);
  assign wr_fire       = awready_q && wready_q && S_AXI_AWVALID && S_AXI_WVALID;
  assign wr_word       = 32'(awaddr_q);
  assign rd_word       = 32'(araddr_q);
  assign unused_ok     = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  // Write address/data acceptance and write response; aw_en blocks a new
  // write until the previous response has been taken.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_en_q   <= 1'b1;
      awaddr_q  <= '0;
      bvalid_q  <= 1'b0;
    end else begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      if (!awready_q && S_AXI_AWVALID && S_AXI_WVALID && aw_en_q) begin
        awready_q <= 1'b1;
        wready_q  <= 1'b1;
        aw_en_q   <= 1'b0;
        awaddr_q  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
      end else if (S_AXI_BREADY && bvalid_q) begin
        aw_en_q   <= 1'b1;
      end
      if (wr_fire) begin
        bvalid_q <= 1'b1;
      end else if (S_AXI_BREADY && bvalid_q) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Next-state of the register file and BRAM write port for an accepted write.
  always_comb begin
    ctrl_d  = ctrl_q;
    ptr_d   = ptr_q;
    wrap_d  = wrap_q;
    cnt_d   = cnt_q;
    wen_d   = '0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (wr_fire) begin
      if (wr_word == 32'd0) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (S_AXI_WSTRB[b]) ctrl_d[b*8 +: 8] = S_AXI_WDATA[b*8 +: 8];
        end
        ctrl_d[31] = 1'b0;
        if (S_AXI_WSTRB[3] && S_AXI_WDATA[31]) begin
          for (int unsigned k = 0; k < NUM_CH; k++) cnt_d[k] = '0;
          wrap_d = 1'b0;
        end
      end else if (wr_word == 32'd1) begin
        for (int unsigned i = 0; i < WF_ADDR_W; i++) begin
          if (S_AXI_WSTRB[i/8]) ptr_d[i] = S_AXI_WDATA[i];
        end
      end else if (wr_word == 32'd2) begin
        if (!chsel_invalid) begin
          for (int unsigned k = 0; k < NUM_CH; k++) begin
            wen_d[k] = (32'(chsel) == k);
            if ((32'(chsel) == k) && (cnt_q[k] != CNT_MAX)) cnt_d[k] = cnt_q[k] + 1'b1;
          end
          waddr_d = ptr_q;
          wdata_d = S_AXI_WDATA[WF_DATA_W-1:0];
          if (auto_inc) begin
            ptr_d = ptr_q + 1'b1;
            if (&ptr_q) wrap_d = 1'b1;
          end
        end
      end else if (wr_word == 32'd3) begin
        if (S_AXI_WSTRB[0] && S_AXI_WDATA[0]) wrap_d = 1'b0;
      end
    end
  end

  // Register file and BRAM write port state.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ctrl_q  <= '0;
      ptr_q   <= '0;
      wrap_q  <= 1'b0;
      for (int unsigned k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
      wen_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      ptr_q   <= ptr_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // Shadow copy of the per-channel read counts, refreshed every clock.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int unsigned k = 0; k < NUM_CH; k++) shadow_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) shadow_q[k] <= i_wf_read_data_num[k*32 +: 32];
    end
  end

  // Read address decode into the register map.
  always_comb begin
    rdata_mux = '0;
    if (rd_word == 32'd0) begin
      rdata_mux = {1'b0, ctrl_q[30:0]};
    end else if (rd_word == 32'd1) begin
      rdata_mux = 32'(ptr_q);
    end else if (rd_word == 32'd3) begin
      rdata_mux = {30'd0, chsel_invalid, wrap_q};
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (rd_word == 4 + k)          rdata_mux = shadow_q[k];
        if (rd_word == 4 + NUM_CH + k) rdata_mux = 32'(cnt_q[k]);
      end
    end
  end

  // Read address acceptance and registered read data.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      arready_q <= 1'b0;
      araddr_q  <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      arready_q <= 1'b0;
      if (!arready_q && S_AXI_ARVALID && !rvalid_q) begin
        arready_q <= 1'b1;
        araddr_q  <= S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
      end
      if (arready_q && S_AXI_ARVALID && !rvalid_q) begin
        rvalid_q <= 1'b1;
        rdata_q  <= C_S_AXI_DATA_WIDTH'(rdata_mux);
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign S_AXI_AWREADY   = awready_q;
  assign S_AXI_WREADY    = wready_q;
  assign S_AXI_BVALID    = bvalid_q;
  assign S_AXI_BRESP     = 2'b00;
  assign S_AXI_ARREADY   = arready_q;
  assign S_AXI_RVALID    = rvalid_q;
  assign S_AXI_RDATA     = rdata_q;
  assign S_AXI_RRESP     = 2'b00;
  assign o_wf_write_en   = wen_q;
  assign o_wf_write_addr = waddr_q;
  assign o_wf_write_data = wdata_q;

endmodule

// File: tb/tb_axi4_lite_wf_loader.sv
// Scoreboard bench for axi4_lite_wf_loader: a register-map model predicts
// read data and BRAM strobes; a monitor compares them as the DUT emits them.
module tb_axi4_lite_wf_loader;

  localparam int NUM_CH = 4;
  localparam int AW     = 8;
  localparam int WAW    = 10;
  localparam int WDW    = 16;
  localparam int DEPTH  = 1 << WAW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [AW-1:0]     awaddr, araddr;
  logic [2:0]        awprot, arprot;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [31:0]       wdata, rdata;
  logic [3:0]        wstrb;
  logic [1:0]        bresp, rresp;
  logic [NUM_CH-1:0] wf_en;
  logic [WAW-1:0]    wf_addr;
  logic [WDW-1:0]    wf_data;
  logic [NUM_CH*32-1:0] rdnum;

  always #5 clk = ~clk;

  axi4_lite_wf_loader #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(AW),
    .NUM_CH(NUM_CH),
    .WF_ADDR_W(WAW),
    .WF_DATA_W(WDW)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr),
    .S_AXI_AWPROT(awprot),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata),
    .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr),
    .S_AXI_ARPROT(arprot),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata),
    .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready),
    .o_wf_write_en(wf_en),
    .o_wf_write_addr(wf_addr),
    .o_wf_write_data(wf_data),
    .i_wf_read_data_num(rdnum)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [NUM_CH-1:0] en;
    logic [WAW-1:0]    addr;
    logic [WDW-1:0]    data;
  } strobe_t;

  strobe_t     exp_wr[$];
  logic [31:0] exp_rd[$];

  // reference model state
  logic [31:0] m_ctrl;
  int unsigned m_ptr;
  bit          m_wrap;
  int unsigned m_cnt [NUM_CH];

  function automatic void model_reset();
    m_ctrl = '0;
    m_ptr  = 0;
    m_wrap = 1'b0;
    foreach (m_cnt[k]) m_cnt[k] = 0;
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{s[b]}};
    return m;
  endfunction

  function automatic void model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    int unsigned w;
    int unsigned ch;
    logic [31:0] m;
    logic [31:0] p;
    strobe_t     st;
    w = 32'(a) / 4;
    m = strb_mask(s);
    if (w == 0) begin
      m_ctrl = ((m_ctrl & ~m) | (d & m)) & 32'h7FFF_FFFF;
      if (s[3] && d[31]) begin
        foreach (m_cnt[k]) m_cnt[k] = 0;
        m_wrap = 1'b0;
      end
    end else if (w == 1) begin
      p = (32'(m_ptr) & ~m) | (d & m);
      m_ptr = p % DEPTH;
    end else if (w == 2) begin
      ch = (m_ctrl >> 8) % 16;
      if (ch < NUM_CH) begin
        st.en = '0;
        st.en[ch] = 1'b1;
        st.addr = WAW'(m_ptr);
        st.data = d[WDW-1:0];
        exp_wr.push_back(st);
        if (m_cnt[ch] < DEPTH) m_cnt[ch] = m_cnt[ch] + 1;
        if (m_ctrl[0]) begin
          if (m_ptr == DEPTH - 1) m_wrap = 1'b1;
          m_ptr = (m_ptr + 1) % DEPTH;
        end
      end
    end else if (w == 3) begin
      if (s[0] && d[0]) m_wrap = 1'b0;
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    int unsigned w;
    int unsigned ch;
    w  = 32'(a) / 4;
    ch = (m_ctrl >> 8) % 16;
    if (w == 0) return m_ctrl;
    if (w == 1) return 32'(m_ptr);
    if (w == 2) return 32'd0;
    if (w == 3) return {30'd0, ch >= NUM_CH, m_wrap};
    if (w < 4 + NUM_CH) return rdnum[(w-4)*32 +: 32];
    if (w < 4 + 2*NUM_CH) return 32'(m_cnt[w-4-NUM_CH]);
    return 32'd0;
  endfunction

  task automatic fail_timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: handshake never seen (got none, required one within budget)", name);
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit hold_b = 1'b0);
    bit ok;
    model_write(a, d, s);
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 16 && !ok; i++) begin
      @(negedge clk);
      ok = awready && wready;
    end
    if (!ok) fail_timeout("aw_w_ready");
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 16 && !ok; i++) begin
      @(negedge clk);
      ok = bvalid;
    end
    if (!ok) fail_timeout("bvalid");
    else begin
      tests++;
      if (bresp !== 2'b00) begin
        fails++;
        $display("FAIL bresp: got %0d required 0", bresp);
      end
    end
    if (!hold_b) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic axi_read(input logic [7:0] a);
    bit ok;
    exp_rd.push_back(model_read(a));
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 16 && !ok; i++) begin
      @(negedge clk);
      ok = arready;
    end
    if (!ok) fail_timeout("arready");
    @(posedge clk); #1;
    arvalid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 16 && !ok; i++) begin
      @(negedge clk);
      ok = rvalid;
    end
    if (!ok) fail_timeout("rvalid");
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outs(input string name);
    tests++;
    if ({awready, wready, bvalid, arready, rvalid, rdata, bresp, rresp} !== '0) begin
      fails++;
      $display("FAIL %s_axi: got aw%0b w%0b b%0b ar%0b r%0b rdata=%h bresp=%0d rresp=%0d required all 0",
               name, awready, wready, bvalid, arready, rvalid, rdata, bresp, rresp);
    end
    tests++;
    if ({wf_en, wf_addr, wf_data} !== '0) begin
      fails++;
      $display("FAIL %s_wf: got en=%b addr=%0d data=%h required all 0", name, wf_en, wf_addr, wf_data);
    end
  endtask

  // Monitor: pops the scoreboard whenever a read beat or a BRAM strobe appears.
  initial begin
    logic [31:0] e;
    strobe_t     st;
    forever begin
      @(negedge clk);
      if (rvalid && rready) begin
        tests++;
        if (exp_rd.size() == 0) begin
          fails++;
          $display("FAIL rd_unexpected: got rdata=%h required no read beat", rdata);
        end else begin
          e = exp_rd.pop_front();
          if (rdata !== e) begin
            fails++;
            $display("FAIL rdata: got %h required %h", rdata, e);
          end
          tests++;
          if (rresp !== 2'b00) begin
            fails++;
            $display("FAIL rresp: got %0d required 0", rresp);
          end
        end
      end
      if (wf_en !== '0) begin
        tests++;
        if (exp_wr.size() == 0) begin
          fails++;
          $display("FAIL strobe_unexpected: got en=%b addr=%0d data=%h required no strobe",
                   wf_en, wf_addr, wf_data);
        end else begin
          st = exp_wr.pop_front();
          if (wf_en !== st.en || wf_addr !== st.addr || wf_data !== st.data) begin
            fails++;
            $display("FAIL strobe: got en=%b addr=%0d data=%h required en=%b addr=%0d data=%h",
                     wf_en, wf_addr, wf_data, st.en, st.addr, st.data);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    int unsigned op;
    logic [31:0] d;
    logic [3:0]  s;
    rst_n = 1'b0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    wdata = '0; wstrb = '0;
    bready = 1'b1; rready = 1'b1;
    for (int k = 0; k < NUM_CH; k++) rdnum[k*32 +: 32] = $urandom;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_outs("reset_init");
    @(negedge clk) rst_n = 1'b1;

    // reset while a WDATA response is pending and its strobe is visible
    axi_write(8'h00, 32'h0000_0001, 4'hF);
    axi_write(8'h04, 32'd9, 4'hF);
    bready = 1'b0;
    axi_write(8'h08, 32'h0000_5555, 4'hF, 1'b1);
    #1 rst_n = 1'b0;
    #1 check_reset_outs("reset_mid_write");
    model_reset();
    bready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    axi_read(8'h04);
    axi_read(8'h00);

    // auto-increment load on channel 2
    axi_write(8'h00, 32'h0000_0201, 4'hF);
    axi_write(8'h04, 32'd5, 4'hF);
    axi_write(8'h08, 32'h0000_1234, 4'hF);
    axi_write(8'h08, 32'h0000_ABCD, 4'hF);
    axi_read(8'h04);
    axi_read(8'h10 + 8'(4 * (NUM_CH + 2)));

    // pointer wrap and W1C of the wrap flag
    axi_write(8'h04, 32'd1023, 4'hF);
    axi_write(8'h08, 32'h0000_0A0A, 4'hF);
    axi_write(8'h08, 32'h0000_0B0B, 4'hF);
    axi_read(8'h0C);
    axi_write(8'h0C, 32'h0000_0001, 4'hF);
    axi_read(8'h0C);

    // invalid channel suppresses everything
    axi_write(8'h00, 32'(NUM_CH) << 8 | 32'h1, 4'hF);
    axi_write(8'h08, 32'h0000_7777, 4'hF);
    axi_read(8'h04);
    axi_read(8'h10 + 8'(4 * (NUM_CH + 2)));
    axi_read(8'h0C);

    // read-back of shadowed counts, write-only and unmapped addresses
    rdnum[3*32 +: 32] = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    axi_read(8'h1C);
    axi_read(8'h08);
    axi_read(8'hFC);

    // clear_counts and byte strobes on CTRL
    axi_write(8'h00, 32'h8000_0201, 4'hF);
    axi_read(8'h10 + 8'(4 * (NUM_CH + 2)));
    axi_read(8'h00);
    axi_write(8'h00, 32'hFFFF_FF55, 4'b0001);
    axi_read(8'h00);

    // counter saturation on channel 1, pointer fixed
    axi_write(8'h00, 32'h0000_0100, 4'hF);
    for (int i = 0; i < DEPTH + 3; i++) axi_write(8'h08, $urandom, 4'hF);
    axi_read(8'h10 + 8'(4 * (NUM_CH + 1)));

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 9);
      s  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      d  = $urandom;
      case (op)
        0: begin
          d[11:8] = 4'($urandom_range(0, NUM_CH));
          d[31]   = ($urandom_range(0, 7) == 0);
          axi_write(8'h00, d, s);
        end
        1: begin
          if ($urandom_range(0, 1) == 1) d = 32'(DEPTH - 1 - $urandom_range(0, 3));
          axi_write(8'h04, d, s);
        end
        2, 3, 4, 5: axi_write(8'h08, d, s);
        6: axi_write(8'($urandom_range(3, 63) * 4), d, s);
        7: begin
          rdnum[$urandom_range(0, NUM_CH-1)*32 +: 32] = $urandom;
          repeat (2) @(posedge clk);
        end
        default: axi_read(8'($urandom_range(0, 63) * 4));
      endcase
    end

    repeat (5) @(posedge clk);
    tests++;
    if (exp_rd.size() != 0) begin
      fails++;
      $display("FAIL rd_leftover: got %0d unanswered reads required 0", exp_rd.size());
    end
    tests++;
    if (exp_wr.size() != 0) begin
      fails++;
      $display("FAIL strobe_leftover: got %0d missing strobes required 0", exp_wr.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi4_lite_wf_loader.md
# axi4_lite_wf_loader

- Parametrised AXI4-Lite slave that loads waveform tables from the PS into NUM_CH dual-port BRAMs.
- Adds channel select, an auto-incrementing write pointer, a single-cycle write strobe per data write, per-channel load counters and a wrap flag.
- Reads back each channel's read-data count for the PS.
- Sits between the PS AXI interconnect and the waveform DPBRAM write ports.

## Interface
Clock and reset: one clock; reset is asynchronous and active-low.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width (fixed 32).
- C_S_AXI_ADDR_WIDTH, 8, AXI byte-address width.
- NUM_CH, 4, number of waveform channels (1..16).
- WF_ADDR_W, 10, BRAM address width.
- WF_DATA_W, 16, BRAM data width (≤32).

Ports:
- S_AXI_ACLK in 1: clock.
- S_AXI_ARESETN in 1: asynchronous active-low reset.
- S_AXI_AW*/W*/B*/AR*/R* AXI4-Lite slave channel signals, standard widths. AWPROT/ARPROT are ignored.
- o_wf_write_en out NUM_CH: one-hot BRAM write strobe.
- o_wf_write_addr out WF_ADDR_W: BRAM write address.
- o_wf_write_data out WF_DATA_W: BRAM write data.
- i_wf_read_data_num in NUM_CH*32: per-channel read count. Channel k is bits [32k+31:32k].

## Operation
Register map (word offsets, ADDR_LSB=2):
- 0x00 CTRL RW:
  - [0] auto_inc.
  - [11:8] channel select. Values ≥ NUM_CH suppress writes.
  - [31] clear_counts, self-clearing, reads 0.
- 0x04 WPTR RW: write loads the pointer (low WF_ADDR_W bits). Read returns the current pointer.
- 0x08 WDATA WO: any write issues one BRAM write. WSTRB is ignored. Reads return 0.
- 0x0C STATUS:
  - [0] wrap sticky, W1C.
  - [1] chsel_invalid (live).
- 0x10+4k, k<NUM_CH, RO: i_wf_read_data_num[k], sampled every clock into a shadow register.
- 0x10+4(NUM_CH+k) RO: load counter k, WF_ADDR_W+1 bits, zero-extended.
- CTRL and WPTR honour WSTRB per byte. Unmapped writes are ignored; unmapped reads return 0. BRESP and RRESP are always OKAY.

WDATA write with a valid channel c:
- The BRAM write uses addr=ptr, data=WDATA[WF_DATA_W-1:0], en bit c.
- counter[c] increments and saturates at 2^WF_ADDR_W.
- If auto_inc: ptr ← ptr+1. At ptr = 2^WF_ADDR_W−1 it wraps to 0 and sets wrap.

WDATA write with an invalid channel: no strobe, no counter change, no pointer change.

clear_counts zeroes all counters and the wrap flag in the same cycle the write is accepted.

## Timing
- Write handshake:
  - Accepted when AWVALID && WVALID && aw_en && !awready. This is cycle T.
  - AWREADY and WREADY pulse high together for one cycle (T+1).
  - Registers update at the end of T+1.
  - BVALID rises at T+2 and holds until BREADY. No new write is accepted while BVALID is high (aw_en).
- WDATA strobe:
  - o_wf_write_en is high for exactly one cycle at T+2.
  - o_wf_write_addr and o_wf_write_data are valid in the same cycle and hold afterwards.
  - The incremented pointer is readable from T+2.
- Read: ARREADY pulses one cycle after ARVALID. RDATA is registered and RVALID rises the next cycle, holding until RREADY.
- Simultaneous read and write: independent. A read at the same cycle as a register update returns the old value.
- Reset, async and mid-transaction:
  - All outputs go to 0 immediately: o_wf_write_en, addr, data, AWREADY, WREADY, BVALID, ARREADY, RVALID, RDATA, BRESP, RRESP.
  - CTRL=0, ptr=0, counters=0, wrap=0, aw_en=1.
  - Any pending strobe is dropped.
- Back-to-back WDATA writes: with BREADY held high, one write is accepted every 3 cycles and strobes never merge.

## Test plan
- Reset: assert ARESETN=0 mid-write with BVALID high → all outputs 0 in the same cycle. After release, WPTR and CTRL read 0.
- Auto-increment load:
  - Setup: CTRL=0x0000_0201 (ch2, auto_inc), WPTR=5.
  - Stimulus: write WDATA 0x1234 then 0xABCD.
  - Required: strobes en=4'b0100 at addr 5/data 0x1234, then addr 6/0xABCD. WPTR reads 7 and counter2 reads 2.
- Wrap:
  - Setup: WPTR=1023, auto_inc on.
  - Stimulus: two WDATA writes.
  - Required: addrs 1023 then 0. STATUS[0]=1; writing 1 to STATUS[0] clears it.
- Invalid channel: CTRL channel=NUM_CH, write WDATA → no en bit set, ptr and counters unchanged, STATUS[1]=1.
- Read-back: drive i_wf_read_data_num channel 3 = 0xDEAD_BEEF → read 0x1C returns 0xDEAD_BEEF. Reading 0x08 or an unmapped address returns 0 with RRESP=OKAY.
- Clear and strobes:
  - Stimulus: CTRL with bit31 after loads; CTRL upper byte written with WSTRB=4'b0001.
  - Required: counters 0 and CTRL[31] reads 0. Only CTRL[7:0] changes.
